// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer countdown controller:
// FSM state encodings and seconds-field constants.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam int                   SEC_WIDTH = 6;
  localparam logic [SEC_WIDTH-1:0] SEC_MAX   = 6'd59;

endpackage

// File: rtl/rise_edge_detect.sv
// One-cycle strobe on each rising edge of a level input that is already
// synchronous to clk_i. Used for the 1 Hz second clock and reusable for buttons.
module rise_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  // Remember the previous level; cleared on reset so a high input right
  // after reset counts as an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer countdown controller: minutes:seconds countdown driven by the
// 1 Hz square wave, with set/start/pause/clear buttons and an alarm at 0:00.
// Optional feature macro: ALARM_AUTO_CLEAR_EN -- when defined, the alarm
// returns to IDLE on its own after ALARM_SECONDS seconds.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | time editable with inc_min/inc_sec, start_stop launches run
// ST_RUN   | time decrements on each second tick
// ST_PAUSE | time held, start_stop resumes
// ST_ALARM | time at 0:00, start_stop reloads the preset and returns
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
`ifdef ALARM_AUTO_CLEAR_EN
  parameter int ALARM_SECONDS = 10,
`endif
  parameter int MAX_MINUTES = 99,
  localparam int MIN_WIDTH  = $clog2(MAX_MINUTES + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 sec_clk_i,
  input  logic                 start_stop_i,
  input  logic                 clear_i,
  input  logic                 inc_min_i,
  input  logic                 inc_sec_i,
  output logic [MIN_WIDTH-1:0] minutes_o,
  output logic [SEC_WIDTH-1:0] seconds_o,
  output logic                 running_o,
  output logic                 alarm_o,
  output logic [1:0]           state_o
);

  localparam logic [MIN_WIDTH-1:0] MIN_MAX = MIN_WIDTH'(MAX_MINUTES);

  logic tick;

  state_e               state_q, state_d;
  logic [MIN_WIDTH-1:0] min_q, min_d, pmin_q, pmin_d, dec_min;
  logic [SEC_WIDTH-1:0] sec_q, sec_d, psec_q, psec_d, dec_sec;
  logic                 running_q, alarm_q;
  logic                 time_zero, dec_zero;

`ifdef ALARM_AUTO_CLEAR_EN
  localparam int ACNT_W = $clog2(ALARM_SECONDS + 1);
  logic [ACNT_W-1:0] acnt_q, acnt_d, acnt_inc;
`endif

  rise_edge_detect u_sec_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (sec_clk_i),
    .pulse_o (tick)
  );

  // State, time, preset and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      pmin_q    <= '0;
      psec_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
`ifdef ALARM_AUTO_CLEAR_EN
      acnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pmin_q    <= pmin_d;
      psec_q    <= psec_d;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_ALARM);
`ifdef ALARM_AUTO_CLEAR_EN
      acnt_q    <= acnt_d;
`endif
    end
  end

  // Next state and time; clear beats tick beats start_stop beats the inc buttons.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pmin_d  = pmin_q;
    psec_d  = psec_q;
    dec_min = min_q;
    dec_sec = sec_q;
`ifdef ALARM_AUTO_CLEAR_EN
    acnt_d   = acnt_q;
    acnt_inc = acnt_q + ACNT_W'(1);
`endif

    if (sec_q != '0) begin
      dec_sec = sec_q - SEC_WIDTH'(1);
    end else begin
      dec_min = min_q - MIN_WIDTH'(1);
      dec_sec = SEC_MAX;
    end
    dec_zero  = (dec_min == '0) && (dec_sec == '0);
    time_zero = (min_q == '0) && (sec_q == '0);

    if (clear_i) begin
      state_d = ST_IDLE;
      min_d   = '0;
      sec_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_stop_i) begin
            // Starting from 0:00 would alarm immediately, so it is ignored.
            if (!time_zero) begin
              pmin_d  = min_q;
              psec_d  = sec_q;
              state_d = ST_RUN;
            end
          end else begin
            if (inc_min_i) min_d = (min_q == MIN_MAX) ? '0 : min_q + MIN_WIDTH'(1);
            if (inc_sec_i) sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + SEC_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (tick) begin
            min_d = dec_min;
            sec_d = dec_sec;
            // Reaching 0:00 wins over a simultaneous pause request.
            if (dec_zero) begin
              state_d = ST_ALARM;
`ifdef ALARM_AUTO_CLEAR_EN
              acnt_d  = '0;
`endif
            end else if (start_stop_i) begin
              state_d = ST_PAUSE;
            end
          end else if (start_stop_i) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_stop_i) state_d = ST_RUN;
        end
        ST_ALARM: begin
`ifdef ALARM_AUTO_CLEAR_EN
          if (start_stop_i || (tick && (acnt_inc == ACNT_W'(ALARM_SECONDS)))) begin
            state_d = ST_IDLE;
            min_d   = pmin_q;
            sec_d   = psec_q;
          end else if (tick) begin
            acnt_d = acnt_inc;
          end
`else
          if (start_stop_i) begin
            state_d = ST_IDLE;
            min_d   = pmin_q;
            sec_d   = psec_q;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign minutes_o = min_q;
  assign seconds_o = sec_q;
  assign running_o = running_q;
  assign alarm_o   = alarm_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: a time-in-seconds model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_egg_timer_ctrl;

  localparam int MAXM = 99;
  localparam int ALS  = 10;

  logic       clk = 1'b0;
  logic       reset, sec_clk, start_stop, clear, inc_min, inc_sec;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running, alarm;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  int m_st, m_min, m_sec, p_min, p_sec, m_acnt;
  bit m_prev;
  bit live = 0;

  always #5 clk = ~clk;

  egg_timer_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .sec_clk_i    (sec_clk),
    .start_stop_i (start_stop),
    .clear_i      (clear),
    .inc_min_i    (inc_min),
    .inc_sec_i    (inc_sec),
    .minutes_o    (minutes),
    .seconds_o    (seconds),
    .running_o    (running),
    .alarm_o      (alarm),
    .state_o      (state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: time kept as fields, countdown done on total seconds.
  always @(posedge clk) begin : model
    bit tk;
    int tot;
    if (reset) begin
      m_st = 0; m_min = 0; m_sec = 0; p_min = 0; p_sec = 0; m_acnt = 0;
      m_prev = 0; live = 1;
    end else begin
      tk = sec_clk && !m_prev;
      m_prev = sec_clk;
      if (clear) begin
        m_st = 0; m_min = 0; m_sec = 0;
      end else begin
        case (m_st)
          0: if (start_stop) begin
               if (m_min * 60 + m_sec > 0) begin
                 p_min = m_min; p_sec = m_sec; m_st = 1;
               end
             end else begin
               if (inc_min) m_min = (m_min + 1) % (MAXM + 1);
               if (inc_sec) m_sec = (m_sec + 1) % 60;
             end
          1: if (tk) begin
               tot = m_min * 60 + m_sec - 1;
               m_min = tot / 60;
               m_sec = tot % 60;
               if (tot == 0) begin
                 m_st = 3; m_acnt = 0;
               end else if (start_stop) m_st = 2;
             end else if (start_stop) m_st = 2;
          2: if (start_stop) m_st = 1;
          3: begin
`ifdef ALARM_AUTO_CLEAR_EN
               if (tk) m_acnt++;
               if (start_stop || m_acnt == ALS) begin
                 m_st = 0; m_min = p_min; m_sec = p_sec;
               end
`else
               if (start_stop) begin
                 m_st = 0; m_min = p_min; m_sec = p_sec;
               end
`endif
             end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("mdl_minutes", 32'(minutes), 32'(m_min));
      chk("mdl_seconds", 32'(seconds), 32'(m_sec));
      chk("mdl_state",   32'(state),   32'(m_st));
      chk("mdl_running", 32'(running), 32'(m_st == 1));
      chk("mdl_alarm",   32'(alarm),   32'(m_st == 3));
    end
  end

  task automatic step(input bit ss, input bit cl, input bit im, input bit is);
    start_stop = ss; clear = cl; inc_min = im; inc_sec = is;
    @(posedge clk); #1;
    start_stop = 0; clear = 0; inc_min = 0; inc_sec = 0;
  endtask

  // One second: rising edge of sec_clk, optionally with a start_stop press.
  task automatic tick_ss(input bit ss);
    sec_clk = 1;
    step(ss, 0, 0, 0);
    step(0, 0, 0, 0);
    sec_clk = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic lit(input string nm, input int mn, input int sc, input int st);
    chk({nm, "_min"},   32'(minutes), 32'(mn));
    chk({nm, "_sec"},   32'(seconds), 32'(sc));
    chk({nm, "_state"}, 32'(state),   32'(st));
    chk({nm, "_alarm"}, 32'(alarm),   32'(st == 3));
  endtask

  initial begin
    reset = 1; sec_clk = 1;
    start_stop = 0; clear = 0; inc_min = 0; inc_sec = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    lit("reset", 0, 0, 0);
    step(0, 0, 0, 0);
    lit("idle_tick", 0, 0, 0);
    sec_clk = 0;
    step(0, 0, 0, 0);

    repeat (61) step(0, 0, 0, 1);
    lit("sec_wrap", 0, 1, 0);
    repeat (MAXM + 2) step(0, 0, 1, 0);
    lit("min_wrap", 1, 1, 0);
    step(0, 0, 0, 1);
    lit("set_102", 1, 2, 0);

    step(1, 0, 0, 0);
    lit("start", 1, 2, 1);
    chk("start_running", 32'(running), 32'd1);
    tick_ss(0); lit("t1", 1, 1, 1);
    tick_ss(0); lit("t2", 1, 0, 1);
    tick_ss(0); lit("t3", 0, 59, 1);
    repeat (58) tick_ss(0);
    lit("t61", 0, 1, 1);
    sec_clk = 1;
    step(0, 0, 0, 0);
    lit("t62_alarm", 0, 0, 3);
    step(0, 0, 0, 0);
    sec_clk = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    lit("ack_preset", 1, 2, 0);

    step(0, 0, 1, 1);
    lit("both_inc", 2, 3, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    lit("inc_in_run", 2, 3, 1);

    step(0, 1, 0, 0);
    lit("clr_run", 0, 0, 0);
    repeat (5) step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    tick_ss(1);
    lit("tick_pause", 0, 4, 2);
    repeat (3) tick_ss(0);
    lit("pause_hold", 0, 4, 2);
    step(1, 0, 0, 0);
    lit("resume", 0, 4, 1);
    tick_ss(0);
    lit("resume_tick", 0, 3, 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    lit("clr_pause", 0, 0, 0);

    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    tick_ss(1);
    lit("alarm_over_pause", 0, 0, 3);
    step(1, 0, 0, 0);
    lit("rerun_ready", 0, 1, 0);
    step(1, 0, 0, 0);
    tick_ss(0);
    lit("alarm2", 0, 0, 3);
    step(0, 1, 0, 0);
    lit("clr_alarm", 0, 0, 0);
    step(1, 0, 0, 0);
    lit("start_at_zero", 0, 0, 0);

`ifdef ALARM_AUTO_CLEAR_EN
    repeat (2) step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    repeat (2) tick_ss(0);
    lit("auto_alarm", 0, 0, 3);
    repeat (ALS - 1) tick_ss(0);
    lit("auto_hold", 0, 0, 3);
    tick_ss(0);
    lit("auto_clear", 0, 2, 0);
`endif

    repeat (3) step(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
